// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer state encoding and op classification for alu_seq_arbiter.
package alu_seq_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_OR         = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD        = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL        = 5'd12;
  localparam logic [OP_W-1:0] OP_DIV        = 5'd13;
  localparam logic [OP_W-1:0] OP_LAST_VALID = 5'd13;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Multiply and divide need extra settle cycles on the shared ALU.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_arbiter_if.sv
// Request, ALU and response signals of alu_seq_arbiter; slave = sequencer side.
interface alu_seq_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic                    req0_valid, req0_ready;
  logic [4:0]              req0_op;
  logic [DATA_WIDTH-1:0]   req0_a, req0_b;
  logic                    req1_valid, req1_ready;
  logic [4:0]              req1_op;
  logic [DATA_WIDTH-1:0]   req1_a, req1_b;
  logic [DATA_WIDTH-1:0]   alu_a, alu_b;
  logic [4:0]              alu_op;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic                    rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*DATA_WIDTH-1:0] rsp_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant; the pointer remembers the last accepted requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);
  logic last;

  // A lone requester wins outright; on a tie (or no request) favour the one not granted last.
  always_comb begin
    grant = ~last;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear)       last <= 1'b1;
    else if (accept) last <= grant;
  end
endmodule

// File: rtl/alu_seq_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared combinational ALU.
// Optional ALU_SEQ_PERF_EN adds a saturating count of completed responses on perf_ops.
module alu_seq_arbiter
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MULDIV_WAIT = 4
) (
  input  logic clk,
  input  logic clear,
  alu_seq_arbiter_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops
`endif
);
  localparam logic [3:0] WAIT_INIT = 4'(MULDIV_WAIT - 1);

  state_t                  state, state_nxt;
  logic                    grant, accept, capture;
  logic [OP_W-1:0]         op_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic                    id_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  logic [3:0]              wait_cnt;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .clear  (clear),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req0_ready = !clear && (state == IDLE) && !grant;
  assign bus.req1_ready = !clear && (state == IDLE) &&  grant;
  assign accept = (bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid);

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (is_muldiv(op_q)) state_nxt = WAIT;
        else begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly and only change on the next accept.
  always_ff @(posedge clk) begin
    if (clear) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        id_q <= grant;
        op_q <= grant ? bus.req1_op : bus.req0_op;
        a_q  <= grant ? bus.req1_a  : bus.req0_a;
        b_q  <= grant ? bus.req1_b  : bus.req0_b;
      end
      if (state == ISSUE && is_muldiv(op_q))      wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (capture) result_q <= bus.alu_result;
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = (op_q > OP_LAST_VALID);

`ifdef ALU_SEQ_PERF_EN
  logic rsp_fire;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (clear)                            perf_ops <= '0;
    else if (rsp_fire && perf_ops != '1) perf_ops <= perf_ops + 32'd1;
  end
`endif
endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Directed plus random bench for alu_seq_arbiter against a transaction-level model.
module tb_alu_seq_arbiter;
  localparam int DW = 32;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  alu_seq_arbiter_if #(.DATA_WIDTH(DW)) bus ();
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_ops;
`endif

  alu_seq_arbiter #(.DATA_WIDTH(DW), .MULDIV_WAIT(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops (perf_ops)
`endif
  );

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return {32'd0, a | b};
      5'd1:    return {32'd0, a & b};
      5'd2:    return {32'd0, a ^ b};
      5'd9:    return {32'd0, a} + {32'd0, b};
      5'd10:   return {32'd0, a - b};
      5'd12:   return {32'd0, a} * {32'd0, b};
      5'd13:   return (b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'd0, a / b};
      default: return (op <= 5'd13) ? {a, b} : 64'd0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  int errors = 0;
  int checks = 0;

  // Model: one transaction in flight, response due a fixed number of cycles after accept.
  bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
  int          m_cyc = 0, m_lat = 0, acc_cnt = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [4:0]  m_op = '0;

  bit          s_r0, s_r1, s_rv, s_id, s_err, acc0, acc1;
  logic [63:0] s_res;
  logic [31:0] s_alu_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Sample at the falling edge, compare against the model, advance the model, then
  // return just after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    bit v0, v1, ea0, ea1, erv;
    logic [4:0] op;
    @(negedge clk);
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    ea0 = !clear && !m_busy && v0 && (!v1 ||  m_last);
    ea1 = !clear && !m_busy && v1 && (!v0 || !m_last);
    erv = m_busy && (m_cyc >= m_lat);
    s_r0 = bus.req0_ready; s_r1 = bus.req1_ready; s_rv = bus.rsp_valid;
    s_id = bus.rsp_id; s_err = bus.rsp_err; s_res = bus.rsp_result; s_alu_a = bus.alu_a;
    chk("ready_excl", 64'(s_r0 && s_r1), 64'(0));
    if (clear || m_busy) begin
      chk("ready0_off", 64'(s_r0), 64'(0));
      chk("ready1_off", 64'(s_r1), 64'(0));
    end
    chk("accept0", 64'(s_r0 && v0), 64'(ea0));
    chk("accept1", 64'(s_r1 && v1), 64'(ea1));
    chk("alu_a", 64'(bus.alu_a), 64'(m_a));
    chk("alu_b", 64'(bus.alu_b), 64'(m_b));
    chk("alu_op", 64'(bus.alu_op), 64'(m_op));
    if (!clear) begin
      chk("rsp_valid", 64'(s_rv), 64'(erv));
      if (erv) begin
        chk("rsp_id", 64'(s_id), 64'(m_id));
        chk("rsp_result", s_res, m_res);
        chk("rsp_err", 64'(s_err), 64'(m_err));
      end
    end
    acc0 = s_r0 && v0;
    acc1 = s_r1 && v1;
    if (clear) begin
      m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0;
    end else if (ea0 || ea1) begin
      op     = ea1 ? bus.req1_op : bus.req0_op;
      m_a    = ea1 ? bus.req1_a  : bus.req0_a;
      m_b    = ea1 ? bus.req1_b  : bus.req0_b;
      m_op   = op;
      m_busy = 1'b1; m_cyc = 1; m_id = ea1; m_last = ea1;
      m_res  = alu_fn(op, m_a, m_b);
      m_err  = (op > 5'd13);
      m_lat  = (op == 5'd12 || op == 5'd13) ? 2 + W : 2;
      acc_cnt++;
    end else if (m_busy) begin
      if (erv && bus.rsp_ready) m_busy = 1'b0;
      else m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40 && m_busy; k++) cycle();
  endtask

  task automatic run_op(input string tag, input bit id, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] er, input bit ee, input int elat);
    int lat;
    bit got;
    bus.rsp_ready = 1'b1;
    set_req(id, 1'b1, op, a, b);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = id ? acc1 : acc0;
    end
    chk({tag, "_accept"}, 64'(got), 64'(1));
    set_req(id, 1'b0, 5'd0, 32'd0, 32'd0);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      cycle();
      if (s_rv) lat = k;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_result"}, s_res, er);
    chk({tag, "_id"}, 64'(s_id), 64'(id));
    chk({tag, "_err"}, 64'(s_err), 64'(ee));
  endtask

  task automatic rand_req(input bit id);
    logic [4:0] op;
    int r;
    r = $urandom_range(0, 3);
    if (r == 0)      op = 5'($urandom_range(0, 31));
    else if (r == 1) op = 5'($urandom_range(12, 13));
    else             op = 5'($urandom_range(0, 13));
    set_req(id, 1'b1, op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int ids[4], ts[4], k, n;
    bit got;
    clear = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'd1, 32'd2);
    set_req(1, 1'b1, 5'd9, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    clear = 1'b0;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    chk("reset_rsp_valid", 64'(s_rv), 64'(0));
    chk("reset_rsp_id", 64'(s_id), 64'(0));
    chk("reset_rsp_err", 64'(s_err), 64'(0));
    chk("reset_rsp_result", s_res, 64'(0));
    chk("reset_alu_a", 64'(s_alu_a), 64'(0));

    run_op("add", 1'b0, 5'd9, 32'd5, 32'd7, 64'd12, 1'b0, 2);
    run_op("mul", 1'b1, 5'd12, 32'h1_0000, 32'h1_0000, 64'h1_0000_0000, 1'b0, 2 + W);
    run_op("div", 1'b0, 5'd13, 32'd100, 32'd7, 64'd14, 1'b0, 2 + W);
    run_op("undef", 1'b1, 5'd20, 32'd9, 32'd9, 64'd0, 1'b1, 2);

    // Both requesters stay valid: grants alternate, 3 cycles apart.
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 5'd9, 32'd10, 32'd1);
    set_req(1, 1'b1, 5'd10, 32'd10, 32'd1);
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      cycle();
      if (acc0 || acc1) begin
        ids[k] = int'(acc1); ts[k] = c; k++;
      end
    end
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("alt_count", 64'(k), 64'(4));
    for (int i = 0; i < 4; i++) chk("alt_id", 64'(ids[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) chk("alt_gap", 64'(ts[i] - ts[i-1]), 64'(3));
    drain();

    // Backpressure: response held 5 cycles, pending req1 waits.
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'd100, 32'd23);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin cycle(); got = acc0; end
    chk("bp_accept", 64'(got), 64'(1));
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 5'd10, 32'd50, 32'd8);
    n = 0;
    while (n < 10 && !s_rv) begin cycle(); n++; end
    chk("bp_rsp_seen", 64'(s_rv), 64'(1));
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("bp_hold_valid", 64'(s_rv), 64'(1));
      chk("bp_hold_result", s_res, 64'd123);
      chk("bp_no_ready", 64'(s_r0 || s_r1), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk("bp_final_valid", 64'(s_rv), 64'(1));
    cycle();
    chk("bp_next_accept1", 64'(acc1), 64'(1));
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    drain();

    // Clear during WAIT drops the op and resets the tie pointer.
    set_req(0, 1'b1, 5'd12, 32'd3, 32'd4);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin cycle(); got = acc0; end
    chk("clr_accept", 64'(got), 64'(1));
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
    chk("clr_rsp_valid", 64'(s_rv), 64'(0));
    chk("clr_alu_a", 64'(s_alu_a), 64'(0));
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("clr_no_rsp", 64'(s_rv), 64'(0));
    end
    set_req(0, 1'b1, 5'd9, 32'd1, 32'd1);
    set_req(1, 1'b1, 5'd9, 32'd2, 32'd2);
    cycle();
    chk("clr_tie_req0", 64'(acc0), 64'(1));
    chk("clr_tie_req1", 64'(acc1), 64'(0));
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    drain();

    // Random traffic with random backpressure and occasional clear.
    acc_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      if (acc0 || !bus.req0_valid) begin
        if ($urandom_range(0, 2) == 0) rand_req(1'b0);
        else set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
      end
      if (acc1 || !bus.req1_valid) begin
        if ($urandom_range(0, 2) == 0) rand_req(1'b1);
        else set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear = 1'b0;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0);
    drain();
    chk("rand_accepts", 64'(acc_cnt > 20), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_arbiter.md
# alu_seq_arbiter

Two-requester round-robin arbiter and sequencer in front of the shared combinational ALU. Accepts operation requests over valid/ready handshakes and registers the operands and opcode. Holds them stable on the ALU inputs for the required number of cycles, with extra settle cycles for multiply and divide. Captures the 64-bit result and returns it, tagged with the requester ID, over a response handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; the result width is 2*DATA_WIDTH.
- MULDIV_WAIT, 4, extra settle cycles for ops 12 (mul) and 13 (div); legal range 1..15.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- clear  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has an op pending.
- req0_ready  out  1  requester 0 op is accepted this cycle.
- req0_op  in  5  ALU opcode (0..13 defined).
- req0_a, req0_b  in  DATA_WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same meanings for requester 1.
- alu_a, alu_b  out  DATA_WIDTH  operands driven to the ALU.
- alu_op  out  5  opcode driven to the ALU.
- alu_result  in  2*DATA_WIDTH  ALU result.
- rsp_valid  out  1  a response is available.
- rsp_ready  in  1  the consumer accepts the response.
- rsp_id  out  1  ID of the requester that issued the op.
- rsp_result  out  2*DATA_WIDTH  captured result.
- rsp_err  out  1  the opcode was undefined (14..31).

## Operation
States:
- IDLE → ISSUE on a request handshake.
- ISSUE → RESP for a single-cycle op; ISSUE → WAIT for op 12 or 13.
- WAIT → RESP when the wait counter reaches zero.
- RESP → IDLE on the response handshake.

Arbitration:
- Applies in IDLE only: a single valid requester is granted; if both are valid, the requester not granted last wins.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
- The pointer updates only on an accept handshake.

Handshakes:
- reqN_ready = (state==IDLE) && grant==N; at most one ready is high per cycle.
- A requester holds its valid and payload stable until it sees ready.
- On accept, op, a, b and id are registered. alu_a, alu_b and alu_op are driven directly from these registers and stay stable until the next accept.

Result capture:
- Single-cycle ops: result_reg ← alu_result at the end of the ISSUE cycle.
- Ops 12 and 13: the wait counter loads MULDIV_WAIT-1 on ISSUE→WAIT and decrements each WAIT cycle. The result is captured in the WAIT cycle where the counter is 0.
- Opcodes 14..31 are treated as single-cycle; the result is whatever the ALU returns (zero), and rsp_err=1.
- rsp_valid is held high with stable rsp_id, rsp_result and rsp_err until rsp_ready is high. No new request is accepted while in RESP.

## Timing
- Reset values: req0_ready and req1_ready are 0 during clear; once IDLE they follow the ready rule. alu_a=0, alu_b=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, state=IDLE, wait counter=0.
- Latency from the accept edge (cycle T) to rsp_valid: T+2 for single-cycle ops; T+2+MULDIV_WAIT for mul and div.
- With rsp_ready held high, the minimum initiation interval is 3 cycles (IDLE, ISSUE, RESP).
- If rsp_ready is already high when rsp_valid rises, the response completes in that same cycle and the next state is IDLE.
- clear during any state: the transaction is dropped without a response, the state goes to IDLE next cycle, and all outputs take their reset values.
- Both requesters raise valid in the same cycle: only one is accepted; the other stays pending and is granted at the next IDLE.

## Configuration
- ALU_SEQ_PERF_EN defined: adds output perf_ops (32 bits), a count of completed response handshakes. It saturates at all-ones and is cleared by clear.
- ALU_SEQ_PERF_EN undefined: no perf_ops port and no counter logic.

## Structure
- Package alu_seq_pkg holds the opcode localparams (OP_OR=0 … OP_DIV=13, OP_LAST_VALID=13), the state encoding (IDLE, ISSUE, WAIT, RESP), and an is_muldiv(op) function.
- Sub-module rr_arbiter2 contains the two-request round-robin grant logic and last-grant pointer, with inputs req[1:0] and accept and output grant.

## Test plan
- Req0 op 9 (add), a=5, b=7 → req0_ready at T; rsp_valid at T+2 with rsp_result=12, rsp_id=0, rsp_err=0.
- Req1 op 12 (mul), a=0x10000, b=0x10000, MULDIV_WAIT=4 → rsp_valid at T+6 with rsp_result=0x1_0000_0000; alu_a and alu_b stable for all 5 cycles before capture.
- Both valid continuously with rsp_ready=1 → grants alternate 0,1,0,1 starting with 0; each accept is 3 cycles apart.
- rsp_ready held low 5 cycles after rsp_valid → response fields stable, no readys asserted; the handshake in cycle 6 returns to IDLE.
- Op 20 → rsp_result=0, rsp_err=1 at T+2.
- clear asserted in WAIT → next cycle IDLE, rsp_valid=0, no response ever issued; the next request behaves as after reset (req0 wins a tie).
